// File: rtl/ex_operand_stage_pkg.sv
// Shared encodings for the stage-2 -> stage-3 operand register: RV32I opcodes,
// the bubble instruction and the rs1 data-select codes used by Data1Sel.
package ex_operand_stage_pkg;

    typedef enum logic [6:0] {
        OPC_LUI       = 7'b0110111,
        OPC_AUIPC     = 7'b0010111,
        OPC_JAL       = 7'b1101111,
        OPC_JALR      = 7'b1100111,
        OPC_BRANCH    = 7'b1100011,
        OPC_LOAD      = 7'b0000011,
        OPC_STORE     = 7'b0100011,
        OPC_ARI_ITYPE = 7'b0010011,
        OPC_ARI_RTYPE = 7'b0110011,
        OPC_CSR       = 7'b1110011
    } opcode_e;

    localparam logic [31:0] NOP_ENC = 32'h0000_0013;

    localparam logic SEL_RS1 = 1'b0;
    localparam logic SEL_WB  = 1'b1;

    // BRANCH and STORE carry immediate bits in [11:7], not a destination register.
    function automatic logic opc_writes_rd(input logic [6:0] opc);
        return (opc != OPC_BRANCH) && (opc != OPC_STORE);
    endfunction

endpackage

// File: rtl/ex_operand_stage_rs2_fwd_detect.sv
// Combinational rs2 forwarding detector, built only when FWD_RS2_EN is defined:
// flags when the stage-2 instruction reads, as rs2, the register stage 3 is writing.
`ifdef FWD_RS2_EN
module rs2_fwd_detect
    import ex_operand_stage_pkg::*;
(
    input  logic        i_ex_valid,
    input  logic [31:0] i_ex_inst,
    input  logic        i_id_valid,
    input  logic [31:0] i_id_inst,
    output logic        o_fwd2_take
);

    logic [6:0] w_ex_opc;
    logic [6:0] w_id_opc;
    logic [4:0] w_ex_rd;
    logic [4:0] w_id_rs2;
    logic       w_id_uses_rs2;

    assign w_ex_opc = i_ex_inst[6:0];
    assign w_id_opc = i_id_inst[6:0];
    assign w_ex_rd  = i_ex_inst[11:7];
    assign w_id_rs2 = i_id_inst[24:20];

    assign w_id_uses_rs2 = (w_id_opc == OPC_ARI_RTYPE) || (w_id_opc == OPC_STORE) ||
                           (w_id_opc == OPC_BRANCH);

    assign o_fwd2_take = i_ex_valid && i_id_valid && opc_writes_rd(w_ex_opc) &&
                         (w_ex_rd != 5'd0) && (w_id_rs2 == w_ex_rd) && w_id_uses_rs2;

endmodule
`endif

// File: rtl/ex_operand_stage.sv
// Stage-2 -> stage-3 pipeline register with rs1 write-back forwarding and a saturating
// forward counter. Define FWD_RS2_EN to also forward rs2 via rs2_fwd_detect.
module ex_operand_stage
    import ex_operand_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP_ENC,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [31:0]      id_inst,
    input  logic [31:0]      id_pc,
    input  logic [31:0]      id_rs1_data,
    input  logic [31:0]      id_rs2_data,
    input  logic             data1_sel,
    input  logic [31:0]      wb_data,
    output logic             ex_valid,
    output logic [31:0]      ex_inst,
    output logic [31:0]      ex_pc,
    output logic [31:0]      ex_rs1_data,
    output logic [31:0]      ex_rs2_data,
    output logic [CNT_W-1:0] fwd_cnt
);

    logic             r_ex_valid;
    logic [31:0]      r_ex_inst;
    logic [31:0]      r_ex_pc;
    logic [31:0]      r_ex_rs1;
    logic [31:0]      r_ex_rs2;
    logic [CNT_W-1:0] r_fwd_cnt;

    logic             w_fwd_take;
    logic [31:0]      w_rs1_next;
    logic [31:0]      w_rs2_next;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Bubbles carry NOP (rd=x0), so the rd check also screens them out.
    assign w_fwd_take = (data1_sel == SEL_WB) && r_ex_valid &&
                        (r_ex_inst[11:7] != 5'd0) && id_valid;
    assign w_rs1_next = w_fwd_take ? wb_data : id_rs1_data;

`ifdef FWD_RS2_EN
    logic w_fwd2_take;

    rs2_fwd_detect u_rs2_fwd_detect (
        .i_ex_valid  (r_ex_valid),
        .i_ex_inst   (r_ex_inst),
        .i_id_valid  (id_valid),
        .i_id_inst   (id_inst),
        .o_fwd2_take (w_fwd2_take)
    );

    assign w_rs2_next = w_fwd2_take ? wb_data : id_rs2_data;
`else
    assign w_rs2_next = id_rs2_data;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex_valid <= 1'b0;
            r_ex_inst  <= NOP_INST;
            r_ex_pc    <= 32'd0;
            r_ex_rs1   <= 32'd0;
            r_ex_rs2   <= 32'd0;
            r_fwd_cnt  <= '0;
        end else if (flush) begin
            r_ex_valid <= 1'b0;
            r_ex_inst  <= NOP_INST;
            r_ex_pc    <= 32'd0;
            r_ex_rs1   <= 32'd0;
            r_ex_rs2   <= 32'd0;
        end else if (!stall) begin
            r_ex_valid <= id_valid;
            r_ex_inst  <= id_valid ? id_inst : NOP_INST;
            r_ex_pc    <= id_pc;
            r_ex_rs1   <= w_rs1_next;
            r_ex_rs2   <= w_rs2_next;
            if (w_fwd_take) begin
                r_fwd_cnt <= sat_inc(r_fwd_cnt);
            end
        end
    end

    assign ex_valid    = r_ex_valid;
    assign ex_inst     = r_ex_inst;
    assign ex_pc       = r_ex_pc;
    assign ex_rs1_data = r_ex_rs1;
    assign ex_rs2_data = r_ex_rs2;
    assign fwd_cnt     = r_fwd_cnt;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed scenarios then randomized traffic,
// checked against a transaction-level model; a CNT_W=2 copy exercises counter saturation.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, id_valid, data1_sel;
    logic [31:0] id_inst, id_pc, id_rs1_data, id_rs2_data, wb_data;

    logic        ex_valid;
    logic [31:0] ex_inst, ex_pc, ex_rs1_data, ex_rs2_data;
    logic [15:0] fwd_cnt;

    logic        s_valid;
    logic [31:0] s_inst, s_pc, s_rs1, s_rs2;
    logic [1:0]  s_cnt;

    int checks = 0;
    int failures = 0;

    bit          m_valid;
    logic [31:0] m_inst, m_pc, m_rs1, m_rs2;
    int          m_cnt;

    logic [31:0] save_inst, save_pc, save_rs1, save_rs2;
    logic        save_valid;
    logic [15:0] save_cnt;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_inst(id_inst), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .data1_sel(data1_sel), .wb_data(wb_data), .ex_valid(ex_valid), .ex_inst(ex_inst),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .fwd_cnt(fwd_cnt)
    );

    ex_operand_stage #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_inst(id_inst), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .data1_sel(data1_sel), .wb_data(wb_data), .ex_valid(s_valid), .ex_inst(s_inst),
        .ex_pc(s_pc), .ex_rs1_data(s_rs1), .ex_rs2_data(s_rs2), .fwd_cnt(s_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit reads_rs2(input logic [6:0] opc);
        return opc == 7'h33 || opc == 7'h23 || opc == 7'h63;
    endfunction

    function automatic bit has_rd(input logic [6:0] opc);
        return opc != 7'h23 && opc != 7'h63;
    endfunction

    // Architectural effect of one clock edge on the stage-3 contents.
    task automatic model_edge;
        bit take1, take2;
        if (!rst_n) begin
            m_valid = 0; m_inst = 32'h13; m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_cnt = 0;
        end else if (flush) begin
            m_valid = 0; m_inst = 32'h13; m_pc = 0; m_rs1 = 0; m_rs2 = 0;
        end else if (!stall) begin
            take1 = data1_sel && m_valid && (m_inst[11:7] != 0) && id_valid;
            take2 = m_valid && id_valid && has_rd(m_inst[6:0]) && (m_inst[11:7] != 0) &&
                    (id_inst[24:20] == m_inst[11:7]) && reads_rs2(id_inst[6:0]);
`ifndef FWD_RS2_EN
            take2 = 0;
`endif
            m_rs1   = take1 ? wb_data : id_rs1_data;
            m_rs2   = take2 ? wb_data : id_rs2_data;
            m_valid = id_valid;
            m_inst  = id_valid ? id_inst : 32'h13;
            m_pc    = id_pc;
            if (take1) m_cnt++;
        end
    endtask

    task automatic tick;
        logic [31:0] e16, e2;
        model_edge();
        @(posedge clk);
        #1;
        e16 = (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt);
        e2  = (m_cnt > 3) ? 32'd3 : 32'(m_cnt);
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
        chk("ex_inst", ex_inst, m_inst);
        chk("ex_pc", ex_pc, m_pc);
        chk("ex_rs1_data", ex_rs1_data, m_rs1);
        chk("ex_rs2_data", ex_rs2_data, m_rs2);
        chk("fwd_cnt", {16'd0, fwd_cnt}, e16);
        chk("sat_fwd_cnt", {30'd0, s_cnt}, e2);
        chk("sat_ex_rs1", s_rs1, m_rs1);
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2, input logic sel,
                         input logic [31:0] wb);
        id_valid = v; id_inst = inst; id_pc = pc; id_rs1_data = r1;
        id_rs2_data = r2; data1_sel = sel; wb_data = wb;
    endtask

    function automatic logic [31:0] rnd_inst();
        logic [6:0] opcs [6] = '{7'h33, 7'h23, 7'h63, 7'h13, 7'h03, 7'h37};
        logic [6:0] f7 = 7'($urandom);
        logic [2:0] f3 = 3'($urandom);
        return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), f3,
                5'($urandom_range(0, 3)), opcs[$urandom_range(0, 5)]};
    endfunction

    initial begin
        m_valid = 0; m_inst = 32'h13; m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_cnt = 0;
        rst_n = 0; stall = 0; flush = 0;
        drive(1, 32'h00500093, 32'h40, 32'h11, 32'h22, 1, 32'h99);

        // Reset held two cycles with a valid instruction presented
        tick(); tick();
        chk("reset_valid", {31'd0, ex_valid}, 32'd0);
        chk("reset_inst", ex_inst, 32'h13);
        chk("reset_cnt", {16'd0, fwd_cnt}, 32'd0);

        // Plain load
        rst_n = 1;
        drive(1, 32'h00500093, 32'd4, 32'd7, 32'd3, 0, 32'd0);
        tick();
        chk("load_inst", ex_inst, 32'h00500093);
        chk("load_pc", ex_pc, 32'd4);
        chk("load_rs1", ex_rs1_data, 32'd7);
        chk("load_valid", {31'd0, ex_valid}, 32'd1);

        // Forward from rd=x1
        drive(1, 32'h00108113, 32'd8, 32'd100, 32'd0, 1, 32'd5);
        tick();
        chk("fwd_rs1", ex_rs1_data, 32'd5);
        chk("fwd_cnt_one", {16'd0, fwd_cnt}, 32'd1);

        // rd=x0 in stage 3 must never forward
        drive(1, 32'h00500013, 32'd12, 32'd0, 32'd0, 0, 32'd0);
        tick();
        drive(1, 32'h00108113, 32'd16, 32'd100, 32'd0, 1, 32'd5);
        tick();
        chk("x0_rs1", ex_rs1_data, 32'd100);
        chk("x0_cnt", {16'd0, fwd_cnt}, 32'd1);

        // Stall three cycles while the inputs keep changing
        save_valid = ex_valid; save_inst = ex_inst; save_pc = ex_pc;
        save_rs1 = ex_rs1_data; save_rs2 = ex_rs2_data; save_cnt = fwd_cnt;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            drive(1, rnd_inst(), $urandom, $urandom, $urandom, 1, $urandom);
            tick();
        end
        chk("stall_valid", {31'd0, ex_valid}, {31'd0, save_valid});
        chk("stall_inst", ex_inst, save_inst);
        chk("stall_pc", ex_pc, save_pc);
        chk("stall_rs1", ex_rs1_data, save_rs1);
        chk("stall_rs2", ex_rs2_data, save_rs2);
        chk("stall_cnt", {16'd0, fwd_cnt}, {16'd0, save_cnt});

        // Flush wins over stall
        flush = 1;
        tick();
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_inst", ex_inst, 32'h13);
        chk("flush_pc", ex_pc, 32'd0);
        stall = 0; flush = 0;

        // Saturation on the CNT_W=2 copy after a fresh reset
        rst_n = 0;
        tick();
        rst_n = 1;
        drive(1, 32'h00500093, 32'd0, 32'd1, 32'd2, 0, 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h00500093, 32'(4 * i), 32'd1, 32'd2, 1, 32'(50 + i));
            tick();
        end
        chk("sat_at_3", {30'd0, s_cnt}, 32'd3);
        chk("wide_at_5", {16'd0, fwd_cnt}, 32'd5);
        tick();
        chk("sat_stays_3", {30'd0, s_cnt}, 32'd3);

        // rs2 forwarding: add x3 in stage 3, sw x3,0(x2) in stage 2
        drive(1, 32'h002081B3, 32'd20, 32'd0, 32'd0, 0, 32'd0);
        tick();
        drive(1, 32'h00312023, 32'd24, 32'd0, 32'd44, 0, 32'd9);
        tick();
`ifdef FWD_RS2_EN
        chk("rs2_fwd_on", ex_rs2_data, 32'd9);
`else
        chk("rs2_fwd_off", ex_rs2_data, 32'd44);
`endif

        // Mid-operation reset discards the in-flight instruction
        drive(1, 32'h00500093, 32'd28, 32'd1, 32'd1, 0, 32'd0);
        tick();
        rst_n = 0;
        tick();
        chk("midrst_valid", {31'd0, ex_valid}, 32'd0);
        chk("midrst_cnt", {16'd0, fwd_cnt}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            rst_n = ($urandom_range(0, 99) >= 3);
            flush = ($urandom_range(0, 99) < 10);
            stall = ($urandom_range(0, 99) < 15);
            drive(($urandom_range(0, 99) < 85), rnd_inst(), $urandom, $urandom, $urandom,
                  1'($urandom), $urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
